// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, buffers returned words for IF/ID.
// Optional build macro IF_MISALIGN_TRAP_EN adds the IFmisalign port and traps on misaligned redirect targets.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Dpc_ctrl,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        IFvalid,
  output logic [31:0] IFpc,
  output logic [31:0] IFinst
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        IFmisalign
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  fetch_entry_t     fifo_q [FIFO_DEPTH];
  logic [31:0]      tag_q  [FIFO_DEPTH];

  logic             accept_c, push_c, pop_c, credit_c, halt_c, live_rsp_c;
  logic [31:0]      target_c;
  fetch_entry_t     head_c;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign target_c   = redirect_pc;
  assign halt_c     = misalign_q;
  assign misalign_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : misalign_q;
  assign IFmisalign = misalign_q;

  // Trap flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign target_c = redirect_pc & ~32'h3;
  assign halt_c   = 1'b0;
`endif

  // Credit counts both in-flight requests (stale included) and buffered words.
  assign credit_c   = (SUM_W'(out_q) + SUM_W'(cnt_q)) < SUM_W'(FIFO_DEPTH);
  assign imem_req   = (state_q == S_RUN) && !redirect_valid && !halt_c && credit_c;
  assign imem_addr  = fetch_pc_q;
  assign accept_c   = imem_req && imem_gnt;
  assign live_rsp_c = imem_rvalid && (disc_q == '0);
  assign push_c     = live_rsp_c && !redirect_valid;
  assign pop_c      = IFvalid && !Dpc_ctrl && !redirect_valid;

  assign head_c  = fifo_q[rd_ptr_q];
  assign IFvalid = (cnt_q != '0);

  always_comb begin
    IFpc   = '0;
    IFinst = '0;
    if (IFvalid) begin
      IFpc   = head_c.pc;
      IFinst = head_c.inst;
    end
`ifdef IF_MISALIGN_TRAP_EN
    if (misalign_q) IFpc = fetch_pc_q;
`endif
  end

  // Next-state: FSM, PC, credit/discard counters, buffer and tag pointers.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CNT_W'(accept_c) - CNT_W'(imem_rvalid);
    disc_d     = disc_q;
    cnt_d      = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    if (accept_c) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_wr_d   = tag_wr_q + PTR_W'(1);
    end
    if (imem_rvalid && (disc_q != '0)) disc_d = disc_q - CNT_W'(1);
    if (live_rsp_c) tag_rd_d = tag_rd_q + PTR_W'(1);
    if (push_c)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // Redirect wins: everything still in flight becomes stale.
    if (redirect_valid) begin
      fetch_pc_d = target_c;
      disc_d     = out_d;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  // Fetch buffer and request-PC tag queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (push_c)   fifo_q[wr_ptr_q] <= '{pc: tag_q[tag_rd_q], inst: imem_rdata};
      if (accept_c) tag_q[tag_wr_q]  <= fetch_pc_q;
    end
  end

  a_rvalid_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (out_q != '0));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: memory model with in-order responses, expected {pc,inst} queue.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Dpc_ctrl = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        IFvalid;
  logic [31:0] IFpc;
  logic [31:0] IFinst;
`ifdef IF_MISALIGN_TRAP_EN
  logic        IFmisalign;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Dpc_ctrl      (Dpc_ctrl),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .IFvalid       (IFvalid),
    .IFpc          (IFpc),
    .IFinst        (IFinst)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .IFmisalign    (IFmisalign)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] model_pc = '0;
  int          cyc = 0;
  int          npop = 0;
  int          total = 0;
  int          bad = 0;
  bit          rsp_en = 1'b1;
  bit          acc_s, pop_s;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef IF_MISALIGN_TRAP_EN
    return p;
`else
    return p & ~32'h3;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // First half of a cycle (called at negedge): present memory response, sample, score pops.
  task automatic pre();
    if (rsp_en && pend_addr.size() > 0 && cyc >= pend_due[0]) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    acc_s = imem_req && imem_gnt;
    pop_s = IFvalid && !Dpc_ctrl && !redirect_valid;
    if (acc_s) chk("req_addr", imem_addr, model_pc);
    if (pop_s) begin
      npop++;
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(IFvalid), 32'd0);
      end else begin
        chk("IFpc", IFpc, exp_q[0].pc);
        chk("IFinst", IFinst, exp_q[0].inst);
        exp_q.delete(0);
      end
    end
  endtask

  // Second half: clock edge, then update memory and reference model.
  task automatic post();
    logic [31:0] a;
    a = imem_addr;
    @(posedge clk);
    if (imem_rvalid) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (acc_s) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + 1);
      exp_q.push_back('{pc: model_pc, inst: memf(model_pc)});
      model_pc += 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = tgt(redirect_pc);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      pre();
      post();
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    Dpc_ctrl       = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    model_pc = 32'h0000_0000;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_IFvalid", 32'(IFvalid), 32'd0);
    chk("rst_IFpc", IFpc, 32'd0);
    chk("rst_IFinst", IFinst, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("rst_IFmisalign", 32'(IFmisalign), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the bench mid-cycle (after pre) so the caller can inspect, then call post().
  task automatic wait_valid(input string tag, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      pre();
      if (IFvalid) begin
        found = 1'b1;
        break;
      end
      post();
    end
    if (!found) begin
      chk({tag, "_timeout"}, 32'(IFvalid), 32'd1);
      pre();
    end
  endtask

  initial begin
    int n0;
    imem_gnt = 1'b1;
    @(negedge clk);
    do_reset();

    // Boot: no request in the first cycle, first request at RESET_PC in the second.
    pre();
    chk("boot_no_req", 32'(imem_req), 32'd0);
    post();
    pre();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);
    post();
    for (int i = 0; i < 20 && npop < 3; i++) run(1);
    chk("boot_pops", 32'(npop), 32'd3);

    // Stall with a full buffer: head frozen, no requests.
    Dpc_ctrl = 1'b1;
    run(3);
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("stall_valid", 32'(IFvalid), 32'd1);
      chk("stall_pc", IFpc, exp_q[0].pc);
      chk("stall_inst", IFinst, exp_q[0].inst);
      chk("stall_req", 32'(imem_req), 32'd0);
      post();
    end
    Dpc_ctrl = 1'b0;
    run(6);

    // Two fetches outstanding, then redirect to 0x100.
    rsp_en = 1'b0;
    run(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    pre();
    chk("redir_req", 32'(imem_req), 32'd0);
    post();
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    wait_valid("redir100", 20);
    chk("redir100_pc", IFpc, 32'h0000_0100);
    post();
    run(4);

    // Grant withheld: address held, PC not advanced.
    imem_gnt = 1'b0;
    run(2);
    for (int i = 0; i < 4; i++) begin
      pre();
      chk("nogrant_req", 32'(imem_req), 32'd1);
      chk("nogrant_addr", imem_addr, model_pc);
      post();
    end
    imem_gnt = 1'b1;
    run(6);

    // Redirect with a response and a stall in the same cycle.
    rsp_en = 1'b0;
    run(2);
    rsp_en         = 1'b1;
    Dpc_ctrl       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    pre();
    chk("redir_rv_present", 32'(imem_rvalid), 32'd1);
    post();
    redirect_valid = 1'b0;
    pre();
    chk("redir_flushed", 32'(IFvalid), 32'd0);
    post();
    Dpc_ctrl = 1'b0;
    wait_valid("redir300", 20);
    chk("redir300_pc", IFpc, 32'h0000_0300);
    post();
    run(4);

    // PC wrap across 2^32.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    run(1);
    redirect_valid = 1'b0;
    n0 = npop;
    run(14);
    chk("wrap_pops", 32'(npop - n0 >= 4), 32'd1);

    // Async reset mid-traffic, then a redirect during BOOT.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    pre();
    chk("bootredir_req", 32'(imem_req), 32'd0);
    post();
    redirect_valid = 1'b0;
    pre();
    chk("bootredir_req2", 32'(imem_req), 32'd1);
    chk("bootredir_addr", imem_addr, 32'h0000_0400);
    post();
    run(8);

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned redirect traps; aligned redirect recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    run(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("mis_flag", 32'(IFmisalign), 32'd1);
      chk("mis_pc", IFpc, 32'h0000_0102);
      chk("mis_inst", IFinst, 32'd0);
      chk("mis_valid", 32'(IFvalid), 32'd0);
      chk("mis_req", 32'(imem_req), 32'd0);
      post();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    run(1);
    redirect_valid = 1'b0;
    pre();
    chk("mis_clear", 32'(IFmisalign), 32'd0);
    chk("mis_fetch_req", 32'(imem_req), 32'd1);
    chk("mis_fetch_addr", imem_addr, 32'h0000_0200);
    post();
    run(6);
`else
    // Low target bits are ignored without the trap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0503;
    run(1);
    redirect_valid = 1'b0;
    wait_valid("unal", 20);
    chk("unal_pc", IFpc, 32'h0000_0500);
    post();
    run(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
